johnson_seq_ctrl: RTL

- Run-length sequencer and protocol checker for the 5-bit Johnson counter.
- Accepts a start command with a step count and drives the counter's enable for exactly that many clocks; supports abort.
- Monitors the counter output for illegal codes and wrong transitions, and reports the decoded phase index and wrap events to downstream phase-timing logic.

---
 rtl/johnson_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/johnson_seq_ctrl.sv
// ---------------------------------------------------------------------------
// johnson_seq_ctrl
//
// Run-length sequencer and protocol checker for a WIDTH-bit Johnson counter.
// A start command with a step count drives the counter enable (cnt_en) for
// exactly that many clocks. stop aborts the run early. A passive checker
// watches the counter output. It flags illegal codes and wrong transitions
// (sticky seq_err), decodes the phase index, and pulses wrap when the counter
// rolls over from its last code back to all-zeros.
//
// Optional feature macro: JSC_PAUSE_EN
//   When it is defined, the module has a 'pause' input that freezes the
//   enable stream while in RUN. When it is undefined, the port is absent and
//   the logic behaves as if pause were tied low.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   start request, sampled only in IDLE
//   run_len    in   [LEN_W]  number of enable cycles, captured with start
//   stop       in   abort request, sampled only in RUN
//   err_clr    in   clears sticky seq_err (a simultaneous new error wins)
//   pause      in   (JSC_PAUSE_EN only) hold the enable stream in RUN
//   cnt_q      in   [WIDTH]  Johnson counter output
//   cnt_en     out  counter enable, registered
//   busy       out  high in RUN and DONE
//   done       out  one-cycle completion pulse
//   aborted    out  qualifies done: 1 = run ended by stop
//   phase_idx  out  [IDX_W]  registered decoded index of cnt_q
//   wrap       out  one-cycle pulse on the last-code -> 0 transition
//   seq_err    out  sticky protocol error flag
//
// Command handshake: start is a request that is accepted only while busy=0.
// Every accepted command produces exactly one done pulse, and aborted is
// valid in that same cycle. A reset cancels the run in flight, and no done
// is produced for it.
//
// The FSM state is held in the internal signal 'state' (type state_t) so
// that a checker can bind to it.
// ---------------------------------------------------------------------------
module johnson_seq_ctrl #(
  parameter int WIDTH = 5,
  parameter int LEN_W = 8,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] run_len,
  input  logic             stop,
  input  logic             err_clr,
`ifdef JSC_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [IDX_W-1:0] phase_idx,
  output logic             wrap,
  output logic             seq_err
);

  // -------------------------------------------------------------------------
  // Constants and helpers
  // -------------------------------------------------------------------------
  // Last code of the sequence (1000...0). The step after it is all-zeros.
  localparam logic [WIDTH-1:0] LAST_CODE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0] SEQ_LEN   = IDX_W'(2 * WIDTH);
  localparam logic [LEN_W-1:0] ONE_STEP  = LEN_W'(1);

  // Returns 1 when q is one of the 2*WIDTH codes that the Johnson counter
  // walks through starting from all-zeros.
  function automatic logic is_johnson(input logic [WIDTH-1:0] q);
    logic [WIDTH-1:0] code;
    logic             hit;
    code = '0;
    hit  = 1'b0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (q == code) hit = 1'b1;
      code = {code[WIDTH-2:0], ~code[WIDTH-1]};
    end
    return hit;
  endfunction

  function automatic logic [IDX_W-1:0] popcount(input logic [WIDTH-1:0] q);
    logic [IDX_W-1:0] ones;
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + IDX_W'(q[i]);
    end
    return ones;
  endfunction

  // -------------------------------------------------------------------------
  // Pause qualifier
  // -------------------------------------------------------------------------
  logic pause_i;
`ifdef JSC_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Sequencer FSM
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [LEN_W-1:0] remaining, remaining_n;
  logic             cnt_en_n;
  logic             aborted_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      cnt_en    <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      cnt_en    <= cnt_en_n;
      aborted   <= aborted_n;
    end
  end

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    cnt_en_n    = cnt_en;
    aborted_n   = aborted;

    case (state)
      ST_IDLE: begin
        cnt_en_n  = 1'b0;
        aborted_n = 1'b0;
        if (start) begin
          if (run_len != '0) begin
            state_n     = ST_RUN;
            remaining_n = run_len;
            cnt_en_n    = 1'b1;
          end else begin
            // A zero-length run completes at once and never enables the
            // counter.
            state_n = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        if (cnt_en && (remaining == ONE_STEP)) begin
          // The final step takes priority over stop. The run has already
          // finished normally.
          state_n     = ST_DONE;
          remaining_n = '0;
          cnt_en_n    = 1'b0;
          aborted_n   = 1'b0;
        end else if (stop) begin
          state_n     = ST_DONE;
          remaining_n = '0;
          cnt_en_n    = 1'b0;
          aborted_n   = 1'b1;
        end else begin
          // remaining counts the edges at which the counter actually
          // advanced. A step that is in flight when pause rises still counts.
          if (cnt_en) remaining_n = remaining - ONE_STEP;
          cnt_en_n = ~pause_i;
        end
      end

      ST_DONE: begin
        state_n   = ST_IDLE;
        cnt_en_n  = 1'b0;
        aborted_n = 1'b0;
      end

      default: begin
        state_n     = ST_IDLE;
        remaining_n = '0;
        cnt_en_n    = 1'b0;
        aborted_n   = 1'b0;
      end
    endcase
  end

  // Both outputs are decoded directly from the state register, so they
  // carry no combinational input-to-output paths.
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // -------------------------------------------------------------------------
  // Protocol checker and phase decoder
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] prev_q;
  logic             prev_en;
  logic             chk_valid;

  logic [WIDTH-1:0] exp_next;
  logic             code_ok;
  logic             trans_ok;
  logic             err_now;
  logic             wrap_now;
  logic [IDX_W-1:0] ones;
  logic [IDX_W-1:0] idx_calc;
  logic [IDX_W-1:0] phase_idx_n;
  logic             seq_err_n;

  always_comb begin
    exp_next    = {prev_q[WIDTH-2:0], ~prev_q[WIDTH-1]};
    code_ok     = is_johnson(cnt_q);
    trans_ok    = prev_en ? (cnt_q == exp_next) : (cnt_q == prev_q);
    // prev_q holds no real sample until the first clock after reset, so the
    // checks are qualified by chk_valid.
    err_now     = chk_valid && (!code_ok || !trans_ok);
    wrap_now    = prev_en && (prev_q == LAST_CODE) && (cnt_q == '0);

    // The first half of the sequence fills ones from the LSB, so the index
    // equals the number of ones. The second half drains them again, so the
    // index equals 2*WIDTH minus the number of ones.
    ones        = popcount(cnt_q);
    idx_calc    = cnt_q[WIDTH-1] ? (SEQ_LEN - ones) : ones;
    phase_idx_n = code_ok ? idx_calc : phase_idx;

    // A new error wins over a clear that arrives in the same cycle.
    seq_err_n   = seq_err;
    if (err_clr) seq_err_n = 1'b0;
    if (err_now) seq_err_n = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      prev_en   <= 1'b0;
      chk_valid <= 1'b0;
      phase_idx <= '0;
      wrap      <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      prev_q    <= cnt_q;
      prev_en   <= cnt_en;
      chk_valid <= 1'b1;
      phase_idx <= phase_idx_n;
      wrap      <= wrap_now;
      seq_err   <= seq_err_n;
    end
  end

endmodule
